plic_claim_ctrl: RTL and testbench

Interrupt gateway, priority arbiter and claim/complete sequencer for external IRQ sources feeding the core's machine-external interrupt line. Latches per-source requests and selects the highest-priority enabled pending source above a programmable threshold. Hands the winning ID to the CSR/trap unit on claim and re-arms the source on complete. Sits between the peripheral IRQ wires and the core's mip.MEIP input.

---
 rtl/plic_claim_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_plic_claim_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// plic_claim_ctrl
//
// Interrupt gateway, priority arbiter and claim/complete sequencer. It sits
// between the peripheral IRQ wires and the core's machine-external interrupt
// input.
//
// Each source k (IDs 1..IRQ_CNT) has a gateway that moves IDLE -> PENDING ->
// IN_SERVICE -> IDLE. ID 0 is reserved and means "no interrupt". The arbiter
// looks only at sources that are PENDING, enabled and have a non-zero
// priority. It picks the highest priority, and on a tie the lowest ID wins.
// The result is registered every cycle. irq_o is raised when the registered
// winner's priority is strictly above the threshold.
//
// Optional feature (compile-time macro):
//   PLIC_EDGE_TRIGGER_EN  defined   : a 0->1 edge of irq_i in IDLE sets
//                                     PENDING. A held-high level does not
//                                     re-pend after complete.
//                         undefined : level mode. irq_i=1 in IDLE sets
//                                     PENDING. No extra input register.
//
// Ports:
//   clk            core clock; all state changes on the rising edge
//   reset_n        asynchronous active-low reset
//   irq_i          raw source requests, bit k = source k
//   ie_i           per-source enable, bit k = source k
//   cfg_we_i       configuration write strobe
//   cfg_addr_i     0 = threshold, k = priority of source k, others ignored
//   cfg_data_i     configuration write data
//   claim_i        one-cycle claim strobe from the CSR/trap unit
//   claim_id_o     claimed ID, valid the cycle after claim_i, held until the
//                  next claim
//   complete_i     one-cycle completion strobe
//   complete_id_i  ID being completed
//   irq_o          external interrupt request to the core (registered)
// -----------------------------------------------------------------------------
module plic_claim_ctrl #(
    parameter  int IRQ_CNT = 8,
    parameter  int PRIO_W  = 3,
    localparam int ID_W    = $clog2(IRQ_CNT + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [IRQ_CNT:1]   irq_i,
    input  logic [IRQ_CNT:1]   ie_i,
    input  logic               cfg_we_i,
    input  logic [ID_W-1:0]    cfg_addr_i,
    input  logic [PRIO_W-1:0]  cfg_data_i,
    input  logic               claim_i,
    output logic [ID_W-1:0]    claim_id_o,
    input  logic               complete_i,
    input  logic [ID_W-1:0]    complete_id_i,
    output logic               irq_o
);

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_e;

    gw_state_e          gw_state_r [1:IRQ_CNT];
    logic [PRIO_W-1:0]  prio_r     [1:IRQ_CNT];
    logic [PRIO_W-1:0]  thr_r;
    logic [ID_W-1:0]    best_id_r;
    logic [PRIO_W-1:0]  best_prio_r;
    logic               valid_r;
    logic               irq_r;
    logic [ID_W-1:0]    claim_id_r;

    logic [IRQ_CNT:1]   req_s;
    logic               arb_found_s;
    logic [ID_W-1:0]    arb_id_s;
    logic [PRIO_W-1:0]  arb_prio_s;
    logic               claim_take_s;
    logic               thr_we_s;
    logic [PRIO_W-1:0]  thr_nxt_s;
    logic               valid_nxt_s;
    logic [PRIO_W-1:0]  best_prio_nxt_s;
    logic               irq_nxt_s;

`ifdef PLIC_EDGE_TRIGGER_EN
    logic [IRQ_CNT:1]   irq_prev_r;

    // Previous request level, used to detect rising edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_prev_r <= '0;
        end else begin
            irq_prev_r <= irq_i;
        end
    end

    assign req_s = irq_i & ~irq_prev_r;
`else
    assign req_s = irq_i;
`endif

    // A claim is honoured only while the request line is actually up. In the
    // cycle after a claim irq_r is low, so a back-to-back claim returns 0.
    assign claim_take_s = claim_i & irq_r;
    assign thr_we_s     = cfg_we_i & (cfg_addr_i == '0);

    // Priority arbiter. The comparison is strict, so on equal priority the
    // lowest ID stays the winner. Because the running maximum starts at 0,
    // a source with priority 0 can never win.
    always_comb begin
        arb_found_s = 1'b0;
        arb_id_s    = '0;
        arb_prio_s  = '0;
        for (int k = 1; k <= IRQ_CNT; k++) begin
            if ((gw_state_r[k] == GW_PENDING) && ie_i[k] && (prio_r[k] > arb_prio_s)) begin
                arb_found_s = 1'b1;
                arb_id_s    = ID_W'(k);
                arb_prio_s  = prio_r[k];
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Next values of the arbiter result registers and the threshold. irq_r is
    // computed from these so that irq_o is a flop but keeps the same timing
    // as a function of the registered state.
    always_comb begin
        if (claim_take_s) begin
            valid_nxt_s     = 1'b0;
            best_prio_nxt_s = best_prio_r;
        end else begin
            valid_nxt_s     = arb_found_s;
            best_prio_nxt_s = arb_prio_s;
        end
        if (thr_we_s) begin
            thr_nxt_s = cfg_data_i;
        end else begin
            thr_nxt_s = thr_r;
        end
        irq_nxt_s = valid_nxt_s && (best_prio_nxt_s > thr_nxt_s);
    end

    // Per-source gateway state machines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= IRQ_CNT; k++) begin
                gw_state_r[k] <= GW_IDLE;
            end
        end else begin
            for (int k = 1; k <= IRQ_CNT; k++) begin
                case (gw_state_r[k])
                    GW_IDLE: begin
                        if (req_s[k]) begin
                            gw_state_r[k] <= GW_PENDING;
                        end else begin
                            gw_state_r[k] <= GW_IDLE;
                        end
                    end
                    GW_PENDING: begin
                        if (claim_take_s && (best_id_r == ID_W'(k))) begin
                            gw_state_r[k] <= GW_IN_SERVICE;
                        end else begin
                            gw_state_r[k] <= GW_PENDING;
                        end
                    end
                    GW_IN_SERVICE: begin
                        if (complete_i && (complete_id_i == ID_W'(k))) begin
                            gw_state_r[k] <= GW_IDLE;
                        end else begin
                            gw_state_r[k] <= GW_IN_SERVICE;
                        end
                    end
                    default: begin
                        gw_state_r[k] <= GW_IDLE;
                    end
                endcase
            end
        end
    end

    // Configuration registers. Writes to out-of-range addresses fall through
    // without matching any register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_r <= '0;
            for (int k = 1; k <= IRQ_CNT; k++) begin
                prio_r[k] <= '0;
            end
        end else begin
            thr_r <= thr_nxt_s;
            for (int k = 1; k <= IRQ_CNT; k++) begin
                if (cfg_we_i && (cfg_addr_i == ID_W'(k))) begin
                    prio_r[k] <= cfg_data_i;
                end else begin
                    prio_r[k] <= prio_r[k];
                end
            end
        end
    end

    // Registered arbiter result. A successful claim invalidates it for one
    // cycle so the claimed source is never offered twice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r     <= 1'b0;
            best_id_r   <= '0;
            best_prio_r <= '0;
            irq_r       <= 1'b0;
        end else begin
            valid_r <= valid_nxt_s;
            irq_r   <= irq_nxt_s;
            if (claim_take_s) begin
                best_id_r   <= best_id_r;
                best_prio_r <= best_prio_r;
            end else begin
                best_id_r   <= arb_id_s;
                best_prio_r <= arb_prio_s;
            end
        end
    end

    // Claim response. It is updated on every claim strobe and otherwise held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            claim_id_r <= '0;
        end else if (claim_i) begin
            claim_id_r <= claim_take_s ? best_id_r : '0;
        end else begin
            claim_id_r <= claim_id_r;
        end
    end

    assign irq_o      = irq_r;
    assign claim_id_o = claim_id_r;

    plic_claim_ctrl_chk #(
        .IRQ_CNT (IRQ_CNT),
        .ID_W    (ID_W)
    ) u_chk (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq        (irq_r),
        .valid      (valid_r),
        .best_id    (best_id_r),
        .claim_id   (claim_id_r)
    );

endmodule

// -----------------------------------------------------------------------------
// plic_claim_ctrl_chk
//
// Structural invariants of plic_claim_ctrl. This module contains only
// assertions and produces no outputs.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset of the controller
//   irq            registered interrupt request
//   valid          arbiter result valid flag
//   best_id        registered winning ID
//   claim_id       registered claim response
// -----------------------------------------------------------------------------
module plic_claim_ctrl_chk #(
    parameter int IRQ_CNT = 8,
    parameter int ID_W    = 4
) (
    input logic            clk,
    input logic            reset_n,
    input logic            irq,
    input logic            valid,
    input logic [ID_W-1:0] best_id,
    input logic [ID_W-1:0] claim_id
);

    a_irq_needs_valid: assert property (@(posedge clk) disable iff (!reset_n)
        irq |-> valid);

    a_best_id_range: assert property (@(posedge clk) disable iff (!reset_n)
        valid |-> ((best_id != '0) && (best_id <= ID_W'(IRQ_CNT))));

    a_claim_id_range: assert property (@(posedge clk) disable iff (!reset_n)
        claim_id <= ID_W'(IRQ_CNT));

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_plic_claim_ctrl
//
// Self-checking bench for plic_claim_ctrl. The reference model keeps a
// pending set, an in-service set, the configuration, and the snapshot the
// controller offered in the previous cycle. Each cycle it picks a winner by
// scanning for the maximum priority. Directed scenarios run first, followed
// by randomized traffic with a reset pulse in the middle of operation.
// -----------------------------------------------------------------------------
module tb_plic_claim_ctrl;

    localparam int IRQ_CNT = 8;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = $clog2(IRQ_CNT + 1);

    logic               clk = 1'b0;
    logic               reset_n;
    logic [IRQ_CNT:1]   irq_i;
    logic [IRQ_CNT:1]   ie_i;
    logic               cfg_we_i;
    logic [ID_W-1:0]    cfg_addr_i;
    logic [PRIO_W-1:0]  cfg_data_i;
    logic               claim_i;
    logic [ID_W-1:0]    claim_id_o;
    logic               complete_i;
    logic [ID_W-1:0]    complete_id_i;
    logic               irq_o;

    plic_claim_ctrl #(.IRQ_CNT(IRQ_CNT), .PRIO_W(PRIO_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .irq_i         (irq_i),
        .ie_i          (ie_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_data_i    (cfg_data_i),
        .claim_i       (claim_i),
        .claim_id_o    (claim_id_o),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_pend  [1:IRQ_CNT];
    bit m_insvc [1:IRQ_CNT];
    bit m_prev  [1:IRQ_CNT];
    int m_prio  [1:IRQ_CNT];
    int m_thr;
    int m_offer_valid;
    int m_offer_id;
    int m_offer_prio;
    int m_cid;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= IRQ_CNT; k++) begin
            m_pend[k]  = 1'b0;
            m_insvc[k] = 1'b0;
            m_prev[k]  = 1'b0;
            m_prio[k]  = 0;
        end
        m_thr = 0;
        m_offer_valid = 0;
        m_offer_id = 0;
        m_offer_prio = 0;
        m_cid = 0;
    endtask

    function automatic int model_irq();
        return (m_offer_valid != 0 && m_offer_prio > m_thr) ? 1 : 0;
    endfunction

    task automatic idle_inputs();
        cfg_we_i      = 1'b0;
        cfg_addr_i    = '0;
        cfg_data_i    = '0;
        claim_i       = 1'b0;
        complete_i    = 1'b0;
        complete_id_i = '0;
    endtask

    // One clock: advance the model using the current inputs, take the edge,
    // then compare both outputs shortly after it.
    task automatic cycle();
        bit n_pend  [1:IRQ_CNT];
        bit n_insvc [1:IRQ_CNT];
        bit take;
        bit req;
        int win_id;
        int win_pr;
        take = claim_i && (model_irq() != 0);
        // Scan from the top ID down with >=, so on ties the lowest ID wins.
        win_id = 0;
        win_pr = 0;
        for (int k = IRQ_CNT; k >= 1; k--) begin
            if (m_pend[k] && ie_i[k] && m_prio[k] != 0 && m_prio[k] >= win_pr) begin
                win_id = k;
                win_pr = m_prio[k];
            end
        end
        for (int k = 1; k <= IRQ_CNT; k++) begin
`ifdef PLIC_EDGE_TRIGGER_EN
            req = irq_i[k] && !m_prev[k];
`else
            req = irq_i[k];
`endif
            n_pend[k]  = m_pend[k];
            n_insvc[k] = m_insvc[k];
            if (!m_pend[k] && !m_insvc[k] && req) n_pend[k] = 1'b1;
            if (m_pend[k] && take && m_offer_id == k) begin
                n_pend[k]  = 1'b0;
                n_insvc[k] = 1'b1;
            end
            if (m_insvc[k] && complete_i && int'(complete_id_i) == k) n_insvc[k] = 1'b0;
        end
        @(posedge clk);
        for (int k = 1; k <= IRQ_CNT; k++) begin
            m_pend[k]  = n_pend[k];
            m_insvc[k] = n_insvc[k];
            m_prev[k]  = irq_i[k];
        end
        if (claim_i) m_cid = take ? m_offer_id : 0;
        if (take) begin
            m_offer_valid = 0;
        end else begin
            m_offer_valid = (win_id != 0) ? 1 : 0;
            m_offer_id    = win_id;
            m_offer_prio  = win_pr;
        end
        if (cfg_we_i) begin
            if (cfg_addr_i == 0) m_thr = int'(cfg_data_i);
            else if (int'(cfg_addr_i) <= IRQ_CNT) m_prio[int'(cfg_addr_i)] = int'(cfg_data_i);
        end
        #1;
        check("irq_o", int'(irq_o), model_irq());
        check("claim_id_o", int'(claim_id_o), m_cid);
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we_i   = 1'b1;
        cfg_addr_i = ID_W'(addr);
        cfg_data_i = PRIO_W'(data);
        cycle();
        cfg_we_i   = 1'b0;
    endtask

    task automatic do_claim();
        claim_i = 1'b1;
        cycle();
        claim_i = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete_i    = 1'b1;
        complete_id_i = ID_W'(id);
        cycle();
        complete_i    = 1'b0;
    endtask

    initial begin
        int pick;
        reset_n = 1'b0;
        irq_i   = '0;
        ie_i    = '0;
        idle_inputs();
        model_reset();
        #12;
        check("reset_irq_o", int'(irq_o), 0);
        check("reset_claim_id", int'(claim_id_o), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Two equal priorities: the lower ID goes first, then the other one.
        ie_i = '1;
        cfg_write(3, 2);
        cfg_write(5, 2);
        cfg_write(0, 0);
        irq_i[3] = 1'b1;
        irq_i[5] = 1'b1;
        cycle();
        check("t1_latency", int'(irq_o), 0);
        cycle();
        check("t1_irq_up", int'(irq_o), 1);
        do_claim();
        check("t1_claim3", int'(claim_id_o), 3);
        check("t1_irq_gap", int'(irq_o), 0);
        cycle();
        check("t1_irq_back", int'(irq_o), 1);
        do_claim();
        check("t1_claim5", int'(claim_id_o), 5);
        irq_i = '0;
        do_complete(6);
        do_complete(3);
        do_complete(5);

        // Threshold masking, then lowering the threshold.
        cfg_write(2, 1);
        cfg_write(7, 6);
        cfg_write(0, 5);
        irq_i[2] = 1'b1;
        irq_i[7] = 1'b1;
        cycle();
        irq_i = '0;
        cycle();
        do_claim();
        check("t2_claim7", int'(claim_id_o), 7);
        cycle();
        do_claim();
        check("t2_claim_masked", int'(claim_id_o), 0);
        check("t2_irq_masked", int'(irq_o), 0);
        cfg_write(0, 0);
        check("t2_irq_unmasked", int'(irq_o), 1);
        do_claim();
        check("t2_claim2", int'(claim_id_o), 2);
        do_complete(2);
        do_complete(7);

        // A disabled pending source stays pending and wins once re-enabled.
        cfg_write(1, 4);
        ie_i[1]  = 1'b0;
        irq_i[1] = 1'b1;
        cycle();
        irq_i[1] = 1'b0;
        cycle();
        cycle();
        check("t4_irq_disabled", int'(irq_o), 0);
        do_claim();
        check("t4_claim_none", int'(claim_id_o), 0);
        ie_i[1] = 1'b1;
        cycle();
        check("t4_irq_enabled", int'(irq_o), 1);
        do_claim();
        check("t4_claim1", int'(claim_id_o), 1);
        do_complete(1);

        // Randomized traffic with a reset pulse in the middle of operation.
        for (int i = 0; i < 3000; i++) begin
            irq_i = IRQ_CNT'($urandom & $urandom & $urandom);
            ie_i  = ($urandom_range(0, 9) == 0) ? IRQ_CNT'($urandom) : '1;
            cfg_we_i   = ($urandom_range(0, 11) == 0);
            cfg_addr_i = ID_W'($urandom_range(0, 15));
            if (cfg_addr_i == 0)
                cfg_data_i = ($urandom_range(0, 7) == 0) ? 3'd7 : PRIO_W'($urandom_range(0, 2));
            else
                cfg_data_i = PRIO_W'($urandom_range(0, 7));
            claim_i    = ($urandom_range(0, 3) == 0);
            complete_i = ($urandom_range(0, 2) == 0);
            pick = $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 1; k <= IRQ_CNT; k++) begin
                    if (m_insvc[k] && $urandom_range(0, 1) == 0) pick = k;
                end
            end
            complete_id_i = ID_W'(pick);
            cycle();
            if (i == 1500) begin
                #2;
                reset_n = 1'b0;
                #1;
                check("midreset_irq_o", int'(irq_o), 0);
                check("midreset_claim_id", int'(claim_id_o), 0);
                model_reset();
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
